// File: rtl/aes_result_capture.sv
// Captures cipher-core results into a valid/ready holding register and watches done timing.
// Optional DONE_CHECK_EN builds the latency shadow counter and the fault_alarm detector.
module aes_result_capture #(
   parameter int DATA_W  = 128,
   parameter int EXP_LAT = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic              done,
   input  logic [DATA_W-1:0] text_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              overrun,
   output logic              fault_alarm
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_busy;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_overrun;

   logic              w_handshake;
   logic              w_done_eff;
   logic              w_done_ok;
   logic              w_capture;
   logic              w_drop;

   assign w_handshake = r_out_valid & out_ready;
   // A load in the same cycle wins: the coincident done belongs to the abandoned operation.
   assign w_done_eff  = done & ~ld;

`ifdef DONE_CHECK_EN
   logic [3:0] r_cnt;
   logic       r_fault;
   logic       w_done_bad;

   assign w_done_ok  = w_done_eff & (r_state == RUN) & (r_cnt == 4'd1);
   assign w_done_bad = w_done_eff & ~w_done_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= 4'd0;
         r_fault <= 1'b0;
      end else begin
         if (ld) begin
            r_cnt <= 4'(EXP_LAT);
         end else if ((r_state == RUN) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_done_bad) begin
            r_fault <= 1'b1;
         end
      end
   end

   assign fault_alarm = r_fault;
`else
   assign w_done_ok   = w_done_eff & (r_state != IDLE);
   assign fault_alarm = 1'b0;
`endif

   // A result is taken when the holding register is empty or being emptied this cycle.
   assign w_capture = w_done_ok & (~r_out_valid | out_ready);
   assign w_drop    = w_done_ok & r_out_valid & ~out_ready;

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
      w_state_nxt = r_state;
      if (ld) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = IDLE;
            RUN: begin
               if (done) begin
                  w_state_nxt = w_capture ? HOLD : IDLE;
               end
            end
            HOLD: begin
               if (w_capture) begin
                  w_state_nxt = HOLD;
               end else if (w_handshake) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         // NOTE: the wide data register is reset too, so no stale result is visible after reset.
         r_out_data  <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == RUN);
         if (w_capture) begin
            r_out_data  <= text_in;
            r_out_valid <= 1'b1;
         end else if (w_handshake) begin
            r_out_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

   a_lat_range: assert property (@(posedge clk) disable iff (!rst)
      (EXP_LAT >= 2) && (EXP_LAT <= 15));

endmodule

// File: tb/tb_aes_result_capture.sv
// Directed bench for aes_result_capture; expectations follow DONE_CHECK_EN when it is defined.
module tb_aes_result_capture;

`ifdef DONE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam logic [127:0] K1 = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] K2 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] K3 = 128'hA5A5A5A5DEADBEEF0123456789ABCDEF;
   localparam logic [127:0] K4 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

   logic         clk;
   logic         rst;
   logic         ld;
   logic         done;
   logic [127:0] text_in;
   logic         out_ready;
   logic         out_valid;
   logic [127:0] out_data;
   logic         busy;
   logic         overrun;
   logic         fault_alarm;

   int n_cmp = 0;
   int n_err = 0;

   aes_result_capture #(.DATA_W(128), .EXP_LAT(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .ld          (ld),
      .done        (done),
      .text_in     (text_in),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .busy        (busy),
      .overrun     (overrun),
      .fault_alarm (fault_alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      ld        = 1'b0;
      done      = 1'b0;
      text_in   = '0;
      out_ready = 1'b0;
      rst       = 1'b0;
      tick(2);
      rst = 1'b1;
      tick();
   endtask

   // Samples ld on the next edge; returns in cycle 1 of the operation.
   task automatic start_op();
      ld = 1'b1;
      tick();
      ld = 1'b0;
   endtask

   task automatic pulse_done(input logic [127:0] data);
      done    = 1'b1;
      text_in = data;
      tick();
      done    = 1'b0;
      text_in = '0;
   endtask

   initial begin
      rst = 1'b0; ld = 1'b0; done = 1'b0; text_in = '0; out_ready = 1'b0;
      tick(2);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_fault", fault_alarm, 0);
      rst = 1'b1;
      tick();

      // On-time done with a ready consumer.
      out_ready = 1'b1;
      start_op();
      check("s1_busy_c1", busy, 1);
      tick(10);
      check("s1_valid_c11", out_valid, 0);
      tick();
      pulse_done(K1);
      check("s1_valid_c13", out_valid, 1);
      check("s1_data_c13", out_data, K1);
      check("s1_busy_c13", busy, 0);
      check("s1_fault_c13", fault_alarm, 0);
      tick();
      check("s1_valid_c14", out_valid, 0);

      // Early done at cycle 9.
      do_reset();
      out_ready = 1'b1;
      start_op();
      tick(8);
      pulse_done(K2);
      check("s2_fault", fault_alarm, CHK);
      check("s2_valid", out_valid, !CHK);
      check("s2_data", out_data, CHK ? 128'h0 : K2);
      tick();
      check("s2_valid_after", out_valid, 0);

      // Done with no preceding ld.
      do_reset();
      pulse_done(K3);
      check("s3_fault", fault_alarm, CHK);
      check("s3_valid", out_valid, 0);
      check("s3_data", out_data, 0);

      // Back-to-back operations, consumer never ready.
      do_reset();
      start_op();
      tick(11);
      pulse_done(K1);
      check("s4_valid_op1", out_valid, 1);
      start_op();
      check("s4_busy_op2", busy, 1);
      check("s4_valid_op2", out_valid, 1);
      tick(11);
      pulse_done(K4);
      check("s4_valid", out_valid, 1);
      check("s4_data", out_data, K1);
      check("s4_overrun", overrun, 1);
      check("s4_fault", fault_alarm, 0);
      check("s4_busy", busy, 0);

      // Second done coincides with the handshake of the first result.
      do_reset();
      start_op();
      tick(11);
      pulse_done(K1);
      start_op();
      tick(11);
      out_ready = 1'b1;
      pulse_done(K4);
      check("s5_valid", out_valid, 1);
      check("s5_data", out_data, K4);
      check("s5_overrun", overrun, 0);
      tick();
      check("s5_valid_after", out_valid, 0);

      // ld and done together: done ignored, counter restarts.
      do_reset();
      out_ready = 1'b1;
      start_op();
      tick(11);
      ld = 1'b1;
      pulse_done(K2);
      ld = 1'b0;
      check("s6_busy", busy, 1);
      check("s6_valid", out_valid, 0);
      check("s6_fault", fault_alarm, 0);
      tick(11);
      pulse_done(K3);
      check("s6_valid_late", out_valid, 1);
      check("s6_data_late", out_data, K3);
      check("s6_fault_late", fault_alarm, 0);

      // Done well past the expected latency (counter saturated).
      do_reset();
      out_ready = 1'b1;
      start_op();
      tick(14);
      pulse_done(K4);
      check("s7_fault", fault_alarm, CHK);
      check("s7_valid", out_valid, !CHK);

      // Reset mid-operation while a result is held.
      do_reset();
      start_op();
      tick(11);
      pulse_done(K1);
      start_op();
      tick(5);
      check("s8_busy_pre", busy, 1);
      rst = 1'b0;
      #1;
      check("s8_valid", out_valid, 0);
      check("s8_data", out_data, 0);
      check("s8_busy", busy, 0);
      check("s8_overrun", overrun, 0);
      check("s8_fault", fault_alarm, 0);
      tick();
      rst = 1'b1;
      tick(5);
      pulse_done(K2);
      check("s8_fault_after", fault_alarm, CHK);
      check("s8_valid_after", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
